// File: rtl/gate_tt_sweeper.sv
// Stimulus/capture stage for a 4-input combinational gate: sweeps all 16 vectors,
// samples the response after SETTLE cycles and compares against a reference truth table.
module gate_tt_sweeper #(
    parameter logic [15:0] EXPECTED = 16'hE605,
    parameter int unsigned SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  stim,
    input  logic        resp,
    output logic        busy,
    output logic        done,
    output logic [15:0] captured,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err,
    output logic        first_err_valid
);

    localparam logic [3:0] SettleW = 4'(SETTLE);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] captured_q, captured_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  ferr_q, ferr_d;
    logic        fvalid_q, fvalid_d;
    logic        pass_q, pass_d;
    logic [3:0]  bit_pos;

    assign bit_pos = 4'd15 - idx_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        err_d      = err_q;
        ferr_d     = ferr_q;
        fvalid_d   = fvalid_q;
        pass_d     = pass_q;
        case (state_q)
            // FINISH behaves like IDLE for start so sweeps can run back to back
            StIdle, StFinish: begin
                state_d = StIdle;
                if (start) begin
                    state_d    = StRun;
                    idx_d      = 4'd0;
                    cnt_d      = 4'd1;
                    captured_d = 16'h0000;
                    err_d      = 5'd0;
                    ferr_d     = 4'd0;
                    fvalid_d   = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            StRun: begin
                if (cnt_q < SettleW) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    captured_d[bit_pos] = resp;
                    if (resp != EXPECTED[bit_pos]) begin
                        err_d = err_q + 5'd1;
                        if (!fvalid_q) begin
                            ferr_d   = idx_q;
                            fvalid_d = 1'b1;
                        end
                    end
                    if (idx_q == 4'd15) begin
                        state_d = StFinish;
                        idx_d   = 4'd0;
                        pass_d  = (captured_d == EXPECTED);
                    end else begin
                        idx_d = idx_q + 4'd1;
                        cnt_d = 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 4'd0;
            cnt_q      <= 4'd0;
            captured_q <= 16'h0000;
            err_q      <= 5'd0;
            ferr_q     <= 4'd0;
            fvalid_q   <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            err_q      <= err_d;
            ferr_q     <= ferr_d;
            fvalid_q   <= fvalid_d;
            pass_q     <= pass_d;
        end
    end

    // idx is held at zero outside RUN, so stim needs no extra gating
    assign stim            = idx_q;
    assign busy            = (state_q == StRun);
    assign done            = (state_q == StFinish);
    assign captured        = captured_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err       = ferr_q;
    assign first_err_valid = fvalid_q;

endmodule
